// File: rtl/uart_rx_param.sv
// Oversampling UART receiver: mid-bit start check, framing and optional parity.
// Define UART_RX_PARITY_EN to insert a parity bit between data and stop.
module uart_rx_param #(
  parameter int DBIT    = 8,
  parameter int OSR     = 16,
  parameter int SB_TICK = 16
) (
  input  logic            I_CLK,
  input  logic            I_RST,
  input  logic            I_RX,
  input  logic            I_BAUD_TICK,
  input  logic            I_PAR_ODD,
  output logic [DBIT-1:0] O_DATA,
  output logic            O_RX_DONE,
  output logic            O_FRAME_ERR,
  output logic            O_PAR_ERR
);

  localparam int SW = $clog2(SB_TICK);
  localparam int BW = $clog2(DBIT);

  localparam logic [SW-1:0] S_HALF = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OSR - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [BW-1:0]   b;
  logic [DBIT-1:0] sh;
  logic            rx_q;
  logic            rx_s;
  logic            stop_bit;
  logic            stop_now;
  logic            par_next;

  // With SB_TICK == OSR the stop sample and frame end share one tick.
  assign stop_now = (s == S_BIT) ? rx_s : stop_bit;

`ifdef UART_RX_PARITY_EN
  logic par_bit;
  assign par_next = (^sh) ^ par_bit ^ I_PAR_ODD;
`else
  assign par_next = 1'b0 & I_PAR_ODD;
`endif

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state       <= IDLE;
      s           <= '0;
      b           <= '0;
      sh          <= '0;
      rx_q        <= 1'b1;
      rx_s        <= 1'b1;
      stop_bit    <= 1'b1;
      O_DATA      <= '0;
      O_RX_DONE   <= 1'b0;
      O_FRAME_ERR <= 1'b0;
      O_PAR_ERR   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit     <= 1'b0;
`endif
    end else begin
      rx_q        <= I_RX;
      rx_s        <= rx_q;
      O_RX_DONE   <= 1'b0;
      O_FRAME_ERR <= 1'b0;
      O_PAR_ERR   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (I_BAUD_TICK) begin
            if (s == S_HALF) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= '0;
                b     <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        DATA: begin
          if (I_BAUD_TICK) begin
            if (s == S_BIT) begin
              s  <= '0;
              sh <= {rx_s, sh[DBIT-1:1]};
              if (b == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                b <= b + 1'b1;
              end
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (I_BAUD_TICK) begin
            if (s == S_BIT) begin
              s       <= '0;
              par_bit <= rx_s;
              state   <= STOP;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
`endif
        STOP: begin
          if (I_BAUD_TICK) begin
            if (s == S_BIT) begin
              stop_bit <= rx_s;
            end
            if (s == S_STOP) begin
              state       <= IDLE;
              s           <= '0;
              O_DATA      <= sh;
              O_RX_DONE   <= 1'b1;
              O_FRAME_ERR <= ~stop_now;
              O_PAR_ERR   <= par_next;
            end else begin
              s <= s + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised, oversampling UART receiver; successor to the fixed 8N1 receiver.
- Sits between the pad-side RX line and the RX FIFO/host logic.
- Shares the baud generator's I_BAUD_TICK (OSR ticks per bit).
- Adds:
  - configurable data width, oversample ratio and stop length;
  - mid-bit start validation (glitch reject);
  - framing-error flag;
  - optional parity checking.

Parameters:
- DBIT, 8, data bits per frame; legal 5..9.
- OSR, 16, baud ticks per bit; even, legal 8..32.
- SB_TICK, 16, ticks spent in the stop state. Must be >= OSR; OSR = 1 stop bit, 1.5*OSR = 1.5 stop bits, 2*OSR = 2 stop bits.

Ports:
- I_CLK  input  1  system clock
- I_RST  input  1  synchronous active-high reset
- I_RX  input  1  asynchronous serial line; idles high
- I_BAUD_TICK  input  1  one-cycle strobe at OSR x baud rate
- I_PAR_ODD  input  1  parity sense, 1 = odd, 0 = even (used only with UART_RX_PARITY_EN; otherwise ignored)
- O_DATA  output  DBIT  last received word, LSB = first bit on the wire
- O_RX_DONE  output  1  one-cycle pulse: frame complete, O_DATA valid
- O_FRAME_ERR  output  1  qualifies O_RX_DONE: stop bit sampled low
- O_PAR_ERR  output  1  qualifies O_RX_DONE: parity mismatch (tied 0 without UART_RX_PARITY_EN)

Behaviour:
- Clocking and reset:
  - Single clock domain, I_CLK rising edge.
  - I_RST is sampled on the edge only; it has no asynchronous path.
- Reset values:
  - State = IDLE; sample count s = 0; bit count b = 0; shift register = 0.
  - Synchroniser flops = 1 (line idle).
  - O_DATA = 0, O_RX_DONE = 0, O_FRAME_ERR = 0, O_PAR_ERR = 0.
- Synchroniser:
  - I_RX passes through a 2-flop synchroniser giving rx_s.
  - All sampling uses rx_s only; the raw I_RX is never used in logic.
- Counting: s advances only in cycles where I_BAUD_TICK = 1. Non-tick cycles hold all state except IDLE detection.
- IDLE:
  - rx_s = 0 moves to START with s = 0.
  - The move is evaluated every clock, not only on ticks.
- START (mid-bit validation):
  - On the tick where s == OSR/2-1, rx_s is checked.
  - rx_s = 0: go to DATA with s = 0, b = 0.
  - rx_s = 1: glitch; return to IDLE with no outputs.
- DATA:
  - On the tick where s == OSR-1:
    - shift rx_s into the shift-register MSB (right-shift, LSB-first wire order);
    - reset s to 0.
  - When b == DBIT-1, go to PARITY (macro defined) or STOP; otherwise increment b.
- PARITY (macro defined only): on the tick where s == OSR-1, capture rx_s as the parity bit, reset s to 0, go to STOP.
- STOP:
  - On the tick where s == OSR-1, capture stop_bit = rx_s.
  - On the tick where s == SB_TICK-1, the frame completes. When SB_TICK == OSR, both events fall on the same tick and the current rx_s is used.
  - At the clock edge that ends the final stop tick:
    - state returns to IDLE and s = 0;
    - O_DATA is loaded from the shift register;
    - O_RX_DONE = 1 for exactly one cycle;
    - O_FRAME_ERR = ~stop_bit;
    - O_PAR_ERR is computed as below.
- Output timing:
  - O_RX_DONE, O_FRAME_ERR and O_PAR_ERR are registered.
  - O_FRAME_ERR and O_PAR_ERR are valid only while O_RX_DONE = 1; they are 0 otherwise.
  - O_DATA holds its value until the next completed frame.
- Latency: O_RX_DONE rises 1 clock after the final STOP tick; the line-to-state path adds 2 clocks of synchroniser delay.
- Errored frames: still deliver O_DATA and O_RX_DONE, with the error flag set.
- Back-to-back frames: a start bit beginning in the cycle IDLE is re-entered is detected with no dead cycle.
- Overrun: no buffering or overrun detection. The consumer must take O_DATA before the next O_RX_DONE.
- Reset mid-frame: aborts immediately to the reset state with no O_RX_DONE. The next falling edge after reset release is treated as a start bit.
- Line held low (break): produces a frame of all zeros with O_FRAME_ERR = 1, then a new START immediately.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - a PARITY state is inserted after DATA;
  - O_PAR_ERR = (XOR of received data bits XOR parity bit) XOR I_PAR_ODD, i.e. the flag is set when the total number of ones does not match the selected parity sense.
- Undefined:
  - no PARITY state;
  - I_PAR_ODD is unused;
  - O_PAR_ERR is tied 0;
  - frame = start + DBIT + stop.

Test Plan:
- Reset release, then 8N1 frame 0x55 at OSR=16 -> one O_RX_DONE pulse, O_DATA = 0x55, O_FRAME_ERR = 0.
- Low pulse of 3 ticks on an idle line -> no O_RX_DONE; FSM back in IDLE by tick 8; a following valid frame 0xA3 is received correctly.
- Frame 0x3C with the stop bit driven low -> O_RX_DONE with O_DATA = 0x3C and O_FRAME_ERR = 1; next valid frame shows O_FRAME_ERR = 0.
- Frames 0x01, 0xFF, 0x80 back-to-back with no idle gap, DBIT=8, and 0x15 at DBIT=5 -> each word delivered in order, three and one pulses respectively.
- I_RST asserted for 1 clock during data bit 4 -> no O_RX_DONE, outputs return to reset values; the next frame 0x7E is received correctly.
- UART_RX_PARITY_EN, I_PAR_ODD = 0, frame 0x07 -> parity bit 1 gives O_PAR_ERR = 0; parity bit 0 gives O_PAR_ERR = 1.
